car_reset_autoplay: RTL and testbench
=====================================

Name: car_reset_autoplay

Overview:
Parametrised successor to the board-level reset/autoplay generator. It produces a stretched system reset from the async reset, DCM lock and a debounced front-panel button. It also drives NCH independent active-low auto-input channels (coin/start/fire/...). Each channel has runtime-programmable start delay, pulse length and repeat period, timed in tick_ce units. It sits beside the clock manager and feeds the game core's reset and input muxes.

Parameters:
RST_HOLD, 4095, sysclk cycles rst_out stays high after all reset sources clear
RST_W, 16, width of reset stretch counter (must hold RST_HOLD)
DB_CYC, 65535, consecutive stable sysclk cycles before button_db changes
DB_W, 16, width of debounce counter
NCH, 3, number of autoplay channels
CNT_W, 32, width of start/length/period/phase counters

Ports:
sysclk  in  1  system clock; all logic in this domain
reset  in  1  asynchronous, active-high; clears every register
dcm_locked  in  1  DCM lock; low forces the reset hold
button  in  1  raw async reset button, active-high
tick_ce  in  1  timebase enable for autoplay counters (e.g. pixel-clock enable)
auto_en  in  1  autoplay master enable
ch_start  in  NCH*CNT_W  per-channel start delay in ticks, channel i at [i*CNT_W +: CNT_W]
ch_len  in  NCH*CNT_W  per-channel active length in ticks
ch_period  in  NCH*CNT_W  per-channel repeat period in ticks; 0 = one-shot
rst_out  out  1  stretched synchronous reset to the core, active-high
auto_n  out  NCH  registered autoplay outputs, active-low
button_db  out  1  debounced button level

Behaviour:
- Async reset: counters cleared; rst_out=1, auto_n all 1, button_db=0.
- Button path: 2-flop synchroniser, then a debounce counter.
  - Counter clears whenever the synchronised level equals button_db.
  - Otherwise it increments; when it reaches DB_CYC-1, button_db toggles and the counter clears.
  - Glitches shorter than DB_CYC cycles are ignored.
- Reset stretcher: r_cnt clears on any cycle with dcm_locked=0 or button_db=1.
  - Otherwise it increments, saturating at RST_HOLD.
  - rst_out is registered: rst_out <= (r_cnt < RST_HOLD).
  - rst_out falls exactly RST_HOLD+1 sysclk edges after the last clearing cycle.
  - Any re-assertion mid-run restarts the full hold.
- Stretcher state machine: HOLD (rst_out=1) -> RUN when r_cnt==RST_HOLD; RUN -> HOLD on dcm_locked=0 or button_db=1.
- Autoplay channel i (sub-module, one per channel), states IDLE, WAIT, ACTIVE_PH.
  - rst_out=1: state IDLE, counters 0, auto_n[i]=1.
  - IDLE -> WAIT when rst_out=0 and auto_en=1.
  - WAIT: on each tick_ce the delay counter increments. When it reaches ch_start-1, or immediately if ch_start==0, the channel enters ACTIVE_PH with phase=0.
  - ACTIVE_PH, on each tick_ce:
    - period!=0: phase = (phase==period-1) ? 0 : phase+1.
    - period==0: phase saturates at all-ones.
  - Output: channel active iff state==ACTIVE_PH and phase < ch_len. auto_n[i] <= ~active, registered one sysclk after the state/phase update.
  - ch_len==0: never active. ch_len>=ch_period (period!=0): continuously active. One-shot: active for exactly ch_len ticks, then high forever.
- auto_en=0: all counters and states hold and auto_n is forced to 1 on the next sysclk. Re-enabling resumes from the held state.
- Programming inputs are sampled live. Changing them mid-run takes effect on the next comparison with no re-sync. Software changes them only while auto_en=0.
- tick_ce and rst_out both high: reset wins.
- All arithmetic is unsigned CNT_W; no wrap except the explicit period wrap.

Decomposition:
- Package car_pkg holds default constants (RST_HOLD, DB_CYC, CNT_W) and the channel state enum (IDLE, WAIT, ACTIVE_PH).
- Sub-module car_autoplay_chan holds one channel's FSM, delay/phase counters and output register. The top instantiates it NCH times with a generate loop.
- Debounce and stretcher stay in the top.

Test Plan:
- Reset released with dcm_locked=1, RST_HOLD=15 (bench override) -> rst_out=1 for 16 sysclk edges after release, then 0.
- button pulse of DB_CYC-1 cycles (DB_CYC=8) -> button_db stays 0 and rst_out stays 0. Pulse of 8 cycles -> button_db=1 after 8+2 cycles, and rst_out re-asserts for the full hold after button_db falls.
- ch0 start=5, len=3, period=0, tick_ce every cycle -> auto_n[0] low for exactly 3 cycles starting 6 cycles after rst_out falls, then high permanently.
- ch1 start=0, len=2, period=5 -> auto_n[1] pattern low,low,high,high,high repeating. ch2 len=0 -> auto_n[2] always 1.
- auto_en dropped mid-pulse on ch1 -> auto_n=1 next cycle. Re-enabled -> pattern resumes at the held phase.
- dcm_locked dropped during ACTIVE_PH -> rst_out=1, all auto_n=1, channels return to IDLE and restart from WAIT after the hold.

Source files
------------

// File: rtl/car_pkg.sv
// Shared defaults and state encodings for the reset stretcher and autoplay channels.
package car_pkg;

  localparam int RST_HOLD_DEF = 4095;
  localparam int DB_CYC_DEF   = 65535;
  localparam int CNT_W_DEF    = 32;

  // IDLE: parked under reset | WAIT: start delay | ACTIVE_PH: phase counter running
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT      = 2'd1,
    ACTIVE_PH = 2'd2
  } chan_state_e;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } rst_state_e;

endpackage

// File: rtl/car_autoplay_chan.sv
// One autoplay channel: start delay, then a free-running or one-shot phase counter
// whose low region (phase < len) drives the active-low output one cycle later.
module car_autoplay_chan
  import car_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             rst_sync_i,
  input  logic             tick_ce_i,
  input  logic             auto_en_i,
  input  logic [CNT_W-1:0] start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             auto_n_o
);

  chan_state_e      state_q;
  logic [CNT_W-1:0] dly_q;
  logic [CNT_W-1:0] phase_q;
  logic             auto_n_q;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      dly_q    <= '0;
      phase_q  <= '0;
      auto_n_q <= 1'b1;
    end else if (rst_sync_i) begin
      state_q  <= IDLE;
      dly_q    <= '0;
      phase_q  <= '0;
      auto_n_q <= 1'b1;
    end else if (!auto_en_i) begin
      auto_n_q <= 1'b1;
    end else begin
      auto_n_q <= !((state_q == ACTIVE_PH) && (phase_q < len_i));
      case (state_q)
        IDLE: state_q <= WAIT;
        WAIT: begin
          if (start_i == '0) begin
            state_q <= ACTIVE_PH;
            phase_q <= '0;
          end else if (tick_ce_i) begin
            if (dly_q == start_i - CNT_W'(1)) begin
              state_q <= ACTIVE_PH;
              phase_q <= '0;
            end else begin
              dly_q <= dly_q + CNT_W'(1);
            end
          end
        end
        ACTIVE_PH: begin
          if (tick_ce_i) begin
            if (period_i != '0) begin
              phase_q <= (phase_q == period_i - CNT_W'(1)) ? '0 : phase_q + CNT_W'(1);
            end else if (phase_q != '1) begin
              // one-shot: park at all-ones so the output stays inactive
              phase_q <= phase_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign auto_n_o = auto_n_q;

endmodule

// File: rtl/car_reset_autoplay.sv
// Board reset generator: button debounce, reset stretcher held off by DCM lock,
// and NCH autoplay channels released once the stretched reset drops.
module car_reset_autoplay
  import car_pkg::*;
#(
  parameter int RST_HOLD = RST_HOLD_DEF,
  parameter int RST_W    = 16,
  parameter int DB_CYC   = DB_CYC_DEF,
  parameter int DB_W     = 16,
  parameter int NCH      = 3,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 dcm_locked,
  input  logic                 button,
  input  logic                 tick_ce,
  input  logic                 auto_en,
  input  logic [NCH*CNT_W-1:0] ch_start,
  input  logic [NCH*CNT_W-1:0] ch_len,
  input  logic [NCH*CNT_W-1:0] ch_period,
  output logic                 rst_out,
  output logic [NCH-1:0]       auto_n,
  output logic                 button_db
);

  localparam logic [RST_W-1:0] HOLD_MAX = RST_W'(RST_HOLD);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYC - 1);

  logic             btn_meta_q;
  logic             btn_sync_q;
  logic [DB_W-1:0]  db_cnt_q;
  logic             button_db_q;
  logic [RST_W-1:0] r_cnt_q;
  rst_state_e       rst_st_q;
  logic             rst_out_q;
  logic             rst_clr;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      btn_meta_q  <= 1'b0;
      btn_sync_q  <= 1'b0;
      db_cnt_q    <= '0;
      button_db_q <= 1'b0;
    end else begin
      btn_meta_q <= button;
      btn_sync_q <= btn_meta_q;
      if (btn_sync_q == button_db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        db_cnt_q    <= '0;
        button_db_q <= ~button_db_q;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  assign rst_clr = !dcm_locked || button_db_q;

  // In RUN the counter sits at HOLD_MAX, so gating on the state is the same as r_cnt < RST_HOLD
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_cnt_q   <= '0;
      rst_st_q  <= ST_HOLD;
      rst_out_q <= 1'b1;
    end else begin
      rst_out_q <= (rst_st_q == ST_HOLD) && (r_cnt_q < HOLD_MAX);
      if (rst_clr) begin
        r_cnt_q <= '0;
      end else if (r_cnt_q != HOLD_MAX) begin
        r_cnt_q <= r_cnt_q + RST_W'(1);
      end
      case (rst_st_q)
        ST_HOLD: if (!rst_clr && (r_cnt_q == HOLD_MAX)) rst_st_q <= ST_RUN;
        ST_RUN:  if (rst_clr) rst_st_q <= ST_HOLD;
        default: rst_st_q <= ST_HOLD;
      endcase
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    car_autoplay_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .sysclk     (sysclk),
      .reset      (reset),
      .rst_sync_i (rst_out_q),
      .tick_ce_i  (tick_ce),
      .auto_en_i  (auto_en),
      .start_i    (ch_start[gi*CNT_W +: CNT_W]),
      .len_i      (ch_len[gi*CNT_W +: CNT_W]),
      .period_i   (ch_period[gi*CNT_W +: CNT_W]),
      .auto_n_o   (auto_n[gi])
    );
  end

  assign rst_out   = rst_out_q;
  assign button_db = button_db_q;

endmodule

// File: tb/tb_car_reset_autoplay.sv
// Scoreboard bench: stimulus pushes per-cycle expectations, a negedge monitor checks them.
module tb_car_reset_autoplay;

  localparam int NCH   = 3;
  localparam int CNT_W = 32;

  logic                 sysclk = 1'b0;
  logic                 reset = 1'b1;
  logic                 dcm_locked = 1'b1;
  logic                 button = 1'b0;
  logic                 tick_ce = 1'b1;
  logic                 auto_en = 1'b1;
  logic [NCH*CNT_W-1:0] ch_start;
  logic [NCH*CNT_W-1:0] ch_len;
  logic [NCH*CNT_W-1:0] ch_period;
  logic                 rst_out;
  logic [NCH-1:0]       auto_n;
  logic                 button_db;

  car_reset_autoplay #(
    .RST_HOLD (15),
    .RST_W    (16),
    .DB_CYC   (8),
    .DB_W     (16),
    .NCH      (NCH),
    .CNT_W    (CNT_W)
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .dcm_locked (dcm_locked),
    .button     (button),
    .tick_ce    (tick_ce),
    .auto_en    (auto_en),
    .ch_start   (ch_start),
    .ch_len     (ch_len),
    .ch_period  (ch_period),
    .rst_out    (rst_out),
    .auto_n     (auto_n),
    .button_db  (button_db)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    int   sel;
    logic val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic act;

  function automatic logic actual(input int sel);
    case (sel)
      0:       return rst_out;
      1:       return button_db;
      2:       return auto_n[0];
      3:       return auto_n[1];
      default: return auto_n[2];
    endcase
  endfunction

  function automatic string sig_name(input int sel);
    case (sel)
      0:       return "rst_out";
      1:       return "button_db";
      2:       return "auto_n[0]";
      3:       return "auto_n[1]";
      default: return "auto_n[2]";
    endcase
  endfunction

  always @(negedge sysclk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        act = actual(exp_q[i].sel);
        n_checks++;
        if ((exp_q[i].cyc != cyc) || (act !== exp_q[i].val)) begin
          n_fail++;
          $display("FAIL %s cycle %0d (checked at %0d): actual=%0b expected=%0b",
                   sig_name(exp_q[i].sel), exp_q[i].cyc, cyc, act, exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
  end

  task automatic push(input int c, input int sel, input logic v);
    exp_t e;
    e.cyc = c;
    e.sel = sel;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic push_auto(input int c, input logic a0, input logic a1, input logic a2);
    push(c, 2, a0);
    push(c, 3, a1);
    push(c, 4, a2);
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge sysclk);
  endtask

  // rst_out falls at edge 18; ch0 (start 5, len 3, one-shot) low at 25..27
  function automatic logic ch0_exp(input int e);
    return !(e >= 25 && e <= 27);
  endfunction

  // ch1 (start 0, len 2, period 5) low,low,high,high,high from edge 21
  function automatic logic ch1_exp(input int e);
    return !(e >= 21 && ((e - 21) % 5) < 2);
  endfunction

  initial begin
    ch_start  = {32'd3, 32'd0, 32'd5};
    ch_len    = {32'd0, 32'd2, 32'd3};
    ch_period = {32'd4, 32'd5, 32'd0};

    for (int c = 1; c <= 2; c++) begin
      push(c, 0, 1'b1);
      push(c, 1, 1'b0);
      push_auto(c, 1'b1, 1'b1, 1'b1);
    end

    goto(2);
    reset = 1'b0;
    push(3, 0, 1'b1);
    push(10, 0, 1'b1);
    push(17, 0, 1'b1);
    push(18, 0, 1'b0);
    for (int e = 19; e <= 50; e++) begin
      if (e >= 37 && e <= 39) push_auto(e, 1'b1, 1'b1, 1'b1);
      else if (e < 37)        push_auto(e, ch0_exp(e), ch1_exp(e), 1'b1);
      else                    push_auto(e, ch0_exp(e), ch1_exp(e - 3), 1'b1);
    end

    // freeze for three edges in the middle of ch1's low phase
    goto(36);
    auto_en = 1'b0;
    goto(39);
    auto_en = 1'b1;

    push(51, 0, 1'b0);
    push(52, 0, 1'b1);
    push(66, 0, 1'b1);
    push(67, 0, 1'b0);
    for (int e = 51; e <= 80; e++) begin
      if (e < 53) push_auto(e, ch0_exp(e), ch1_exp(e - 3), 1'b1);
      else        push_auto(e, ch0_exp(e - 49), ch1_exp(e - 49), 1'b1);
    end
    goto(50);
    dcm_locked = 1'b0;
    goto(51);
    dcm_locked = 1'b1;

    // 7-cycle glitch ignored; 8-cycle press toggles at edge 115, releases at 123
    for (int e = 86; e <= 114; e++) push(e, 1, 1'b0);
    for (int e = 86; e <= 116; e++) push(e, 0, 1'b0);
    push(115, 1, 1'b1);
    push(122, 1, 1'b1);
    push(123, 1, 1'b0);
    push(117, 0, 1'b1);
    push(138, 0, 1'b1);
    push(139, 0, 1'b0);
    goto(85);
    button = 1'b1;
    goto(92);
    button = 1'b0;
    goto(105);
    button = 1'b1;
    goto(113);
    button = 1'b0;

    // tick_ce off across the restart: ch1 parks at phase 0, ch0 stays in WAIT
    for (int e = 141; e <= 160; e++) begin
      push_auto(e, !(e >= 156 && e <= 158),
                !((e >= 142 && e <= 152) || e == 156 || e == 157), 1'b1);
    end
    goto(135);
    tick_ce = 1'b0;
    goto(150);
    tick_ce = 1'b1;

    goto(162);
    while (exp_q.size() != 0 && cyc < 300) @(negedge sysclk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: cycle=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

endmodule
